// File: rtl/hls_module_status_tracker.sv
// hls_module_status_tracker
//
// Watches NUM_CH ap_ctrl_hs / ap_ctrl_chain control interfaces and keeps
// per-channel activity counters and latency statistics. Each channel has a
// three-state tracker (IDLE, BUSY, DONE_WAIT). A one-cycle-latency readout
// port returns any counter of any channel.
//
// Ports
//   clock        sole clock, all inputs sampled on its rising edge
//   reset        asynchronous, active-low reset
//   ap_start     per-channel start (bit i = channel i)
//   ap_ready     per-channel ready (counted only)
//   ap_done      per-channel done
//   ap_continue  per-channel continue (tie 1 for ap_ctrl_hs channels)
//   cnt_en       per-channel counter enable; the tracker runs regardless
//   cnt_clr      per-channel synchronous clear of the seven statistic regs
//   rd_req       readout request
//   rd_ch        channel to read; out-of-range channels return 0
//   rd_sel       0 start_cnt, 1 ready_cnt, 2 done_cnt, 3 busy_cyc,
//                4 stall_cyc, 5 last_lat, 6 max_lat, 7 status (state)
//   rd_valid     readout data valid
//   rd_data      readout data (latency and status zero-extended)
//   dbg_state    live tracker state, two bits per channel
//
// Readout handshake: rd_req is a single-cycle request with no back-pressure.
// A request sampled at edge N produces rd_valid=1 for exactly the cycle after
// edge N, carrying the register value that was present before edge N. With
// no request rd_valid is 0 and rd_data keeps its previous value.

module hls_module_status_tracker #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int LAT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ap_start,
  input  logic [NUM_CH-1:0]     ap_ready,
  input  logic [NUM_CH-1:0]     ap_done,
  input  logic [NUM_CH-1:0]     ap_continue,
  input  logic [NUM_CH-1:0]     cnt_en,
  input  logic [NUM_CH-1:0]     cnt_clr,
  input  logic                  rd_req,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [2:0]            rd_sel,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      rd_data,
  output logic [2*NUM_CH-1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_DONE_WAIT = 2'd2
  } state_t;

  localparam logic [CH_W:0] NUM_CH_CMP = (CH_W+1)'(NUM_CH);

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  function automatic logic [LAT_W-1:0] inc_lat(input logic [LAT_W-1:0] v);
    return (v != {LAT_W{1'b1}}) ? v + LAT_W'(1) : v;
  endfunction

  // Per-channel readout candidate, selected by rd_sel inside each channel.
  logic [CNT_W-1:0] ch_field [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [LAT_W-1:0] lat_run_q;
    logic [LAT_W-1:0] lat_now;
    logic [LAT_W-1:0] last_lat_q;
    logic [LAT_W-1:0] max_lat_q;
    logic [CNT_W-1:0] start_cnt_q;
    logic [CNT_W-1:0] ready_cnt_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic [CNT_W-1:0] busy_cyc_q;
    logic [CNT_W-1:0] stall_cyc_q;
    logic             acc_start;  // start accepted this cycle
    logic             done_evt;   // transaction completes this cycle
    logic             lat_evt;    // ap_done observed: capture latency
    logic [CNT_W-1:0] field;

    always_comb begin
      state_d   = state_q;
      acc_start = 1'b0;
      done_evt  = 1'b0;
      lat_evt   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ap_start[i]) begin
            acc_start = 1'b1;
            if (ap_done[i]) begin
              lat_evt = 1'b1;
              if (ap_continue[i]) begin
                done_evt = 1'b1;
                state_d  = ST_IDLE;
              end else begin
                state_d  = ST_DONE_WAIT;
              end
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (ap_done[i]) begin
            lat_evt = 1'b1;
            if (ap_continue[i]) begin
              done_evt = 1'b1;
              // Pipelined restart: a start present at completion is taken.
              if (ap_start[i]) begin
                acc_start = 1'b1;
                state_d   = ST_BUSY;
              end else begin
                state_d   = ST_IDLE;
              end
            end else begin
              state_d = ST_DONE_WAIT;
            end
          end
        end
        ST_DONE_WAIT: begin
          if (ap_continue[i]) begin
            done_evt = 1'b1;
            if (ap_start[i]) begin
              acc_start = 1'b1;
              state_d   = ST_BUSY;
            end else begin
              state_d   = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A done in the same cycle as the start out of IDLE has latency 0; the
    // running counter only tracks elapsed cycles once a start is in flight.
    assign lat_now = (state_q == ST_IDLE) ? '0 : lat_run_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q     <= ST_IDLE;
        lat_run_q   <= '0;
        last_lat_q  <= '0;
        max_lat_q   <= '0;
        start_cnt_q <= '0;
        ready_cnt_q <= '0;
        done_cnt_q  <= '0;
        busy_cyc_q  <= '0;
        stall_cyc_q <= '0;
      end else begin
        state_q <= state_d;

        // Value one edge after the accepted start is one elapsed cycle.
        if (acc_start) begin
          lat_run_q <= LAT_W'(1);
        end else if (state_q == ST_BUSY) begin
          lat_run_q <= inc_lat(lat_run_q);
        end

        // Clear takes priority over any increment or latency capture.
        if (cnt_clr[i]) begin
          last_lat_q  <= '0;
          max_lat_q   <= '0;
          start_cnt_q <= '0;
          ready_cnt_q <= '0;
          done_cnt_q  <= '0;
          busy_cyc_q  <= '0;
          stall_cyc_q <= '0;
        end else begin
          if (lat_evt) begin
            last_lat_q <= lat_now;
            if (lat_now > max_lat_q) begin
              max_lat_q <= lat_now;
            end
          end
          start_cnt_q <= inc_cnt(start_cnt_q, cnt_en[i] & acc_start);
          ready_cnt_q <= inc_cnt(ready_cnt_q, cnt_en[i] & ap_ready[i]);
          done_cnt_q  <= inc_cnt(done_cnt_q,  cnt_en[i] & done_evt);
          busy_cyc_q  <= inc_cnt(busy_cyc_q,  cnt_en[i] & (state_q == ST_BUSY));
          stall_cyc_q <= inc_cnt(stall_cyc_q, cnt_en[i] & (state_q == ST_DONE_WAIT));
        end
      end
    end

    always_comb begin
      field = '0;
      case (rd_sel)
        3'd0:    field = start_cnt_q;
        3'd1:    field = ready_cnt_q;
        3'd2:    field = done_cnt_q;
        3'd3:    field = busy_cyc_q;
        3'd4:    field = stall_cyc_q;
        3'd5:    field = CNT_W'(last_lat_q);
        3'd6:    field = CNT_W'(max_lat_q);
        default: field = CNT_W'(state_q);
      endcase
    end

    assign ch_field[i]          = field;
    assign dbg_state[2*i +: 2]  = state_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if ({1'b0, rd_ch} < NUM_CH_CMP) begin
          rd_data <= ch_field[rd_ch];
        end else begin
          rd_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hls_module_status_tracker.sv
module tb_hls_module_status_tracker;

  logic clock;
  logic reset;

  // Instance A: default sizing (4 channels, 32-bit counters, 16-bit latency)
  logic [3:0]  a_ap_start, a_ap_ready, a_ap_done, a_ap_continue, a_cnt_en, a_cnt_clr;
  logic        a_rd_req;
  logic [1:0]  a_rd_ch;
  logic [2:0]  a_rd_sel;
  logic        a_rd_valid;
  logic [31:0] a_rd_data;
  logic [7:0]  a_dbg;

  // Instance B: 3 channels, 4-bit counters, 3-bit latency (saturation, range)
  logic [2:0]  b_ap_start, b_ap_ready, b_ap_done, b_ap_continue, b_cnt_en, b_cnt_clr;
  logic        b_rd_req;
  logic [1:0]  b_rd_ch;
  logic [2:0]  b_rd_sel;
  logic        b_rd_valid;
  logic [3:0]  b_rd_data;
  logic [5:0]  b_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_a[$];
  string       nm_a[$];
  logic [31:0] exp_b[$];
  string       nm_b[$];

  hls_module_status_tracker #(.NUM_CH(4), .CNT_W(32), .LAT_W(16)) dut_a (
    .clock(clock), .reset(reset),
    .ap_start(a_ap_start), .ap_ready(a_ap_ready), .ap_done(a_ap_done),
    .ap_continue(a_ap_continue), .cnt_en(a_cnt_en), .cnt_clr(a_cnt_clr),
    .rd_req(a_rd_req), .rd_ch(a_rd_ch), .rd_sel(a_rd_sel),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .dbg_state(a_dbg)
  );

  hls_module_status_tracker #(.NUM_CH(3), .CNT_W(4), .LAT_W(3)) dut_b (
    .clock(clock), .reset(reset),
    .ap_start(b_ap_start), .ap_ready(b_ap_ready), .ap_done(b_ap_done),
    .ap_continue(b_ap_continue), .cnt_en(b_cnt_en), .cnt_clr(b_cnt_clr),
    .rd_req(b_rd_req), .rd_ch(b_rd_ch), .rd_sel(b_rd_sel),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .dbg_state(b_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic a_req(input int ch, input int sel, input logic [31:0] exp, input string name);
    a_rd_req = 1'b1;
    a_rd_ch  = ch[1:0];
    a_rd_sel = sel[2:0];
    exp_a.push_back(exp);
    nm_a.push_back(name);
  endtask

  task automatic a_read(input int ch, input int sel, input logic [31:0] exp, input string name);
    a_req(ch, sel, exp, name);
    @(negedge clock);
    a_rd_req = 1'b0;
  endtask

  task automatic b_read(input int ch, input int sel, input logic [31:0] exp, input string name);
    b_rd_req = 1'b1;
    b_rd_ch  = ch[1:0];
    b_rd_sel = sel[2:0];
    exp_b.push_back(exp);
    nm_b.push_back(name);
    @(negedge clock);
    b_rd_req = 1'b0;
  endtask

  task automatic a_read_all(input int ch, input logic [31:0] e [8], input string tag);
    for (int s = 0; s < 8; s++) begin
      a_read(ch, s, e[s], $sformatf("%s_sel%0d", tag, s));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clock) begin
    #1;
    if (a_rd_valid) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_valid actual=1 required=0");
      end else begin
        check(nm_a.pop_front(), a_rd_data, exp_a.pop_front());
      end
    end
    if (b_rd_valid) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_valid actual=1 required=0");
      end else begin
        check(nm_b.pop_front(), {28'd0, b_rd_data}, exp_b.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] e [8];

  initial begin
    reset = 1'b0;
    a_ap_start = '0; a_ap_ready = '0; a_ap_done = '0; a_ap_continue = '1;
    a_cnt_en = '1; a_cnt_clr = '0; a_rd_req = 1'b0; a_rd_ch = '0; a_rd_sel = '0;
    b_ap_start = '0; b_ap_ready = '0; b_ap_done = '0; b_ap_continue = '1;
    b_cnt_en = '1; b_cnt_clr = '0; b_rd_req = 1'b0; b_rd_ch = '0; b_rd_sel = '0;

    repeat (2) @(negedge clock);
    check("rst_a_valid", {31'd0, a_rd_valid}, 32'd0);
    check("rst_a_data", a_rd_data, 32'd0);
    check("rst_a_state", {24'd0, a_dbg}, 32'd0);
    check("rst_b_valid", {31'd0, b_rd_valid}, 32'd0);
    check("rst_b_data", {28'd0, b_rd_data}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // ch0: single ap_ctrl_hs transaction, latency 7, one ready pulse
    a_ap_start[0] = 1'b1; a_ap_ready[0] = 1'b1;
    @(negedge clock);
    a_ap_start[0] = 1'b0; a_ap_ready[0] = 1'b0;
    repeat (6) @(negedge clock);
    a_ap_done[0] = 1'b1;
    @(negedge clock);
    a_ap_done[0] = 1'b0;
    e = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd0, 32'd7, 32'd7, 32'd0};
    a_read_all(0, e, "ch0");

    // ch1: ap_ctrl_chain, latency 4, three stall cycles
    a_ap_continue[1] = 1'b0; a_ap_start[1] = 1'b1;
    @(negedge clock);
    a_ap_start[1] = 1'b0;
    repeat (3) @(negedge clock);
    a_ap_done[1] = 1'b1;
    @(negedge clock);
    a_ap_done[1] = 1'b0;
    a_req(1, 7, 32'd2, "ch1_status_in_stall");
    @(negedge clock);
    a_req(1, 2, 32'd0, "ch1_done_before_continue");
    @(negedge clock);
    a_rd_req = 1'b0;
    a_ap_continue[1] = 1'b1;
    @(negedge clock);
    e = '{32'd1, 32'd0, 32'd1, 32'd4, 32'd3, 32'd4, 32'd4, 32'd0};
    a_read_all(1, e, "ch1");

    // ch2: start held high, done every 5 cycles, 4 transactions
    a_ap_start[2] = 1'b1;
    @(negedge clock);
    for (int t = 0; t < 4; t++) begin
      repeat (4) @(negedge clock);
      a_ap_done[2] = 1'b1;
      if (t == 3) a_ap_start[2] = 1'b0;
      @(negedge clock);
      a_ap_done[2] = 1'b0;
    end
    e = '{32'd4, 32'd0, 32'd4, 32'd20, 32'd0, 32'd5, 32'd5, 32'd0};
    a_read_all(2, e, "ch2");

    // ch3: clear coincides with ap_done (continue low -> DONE_WAIT)
    a_ap_start[3] = 1'b1;
    @(negedge clock);
    a_ap_start[3] = 1'b0;
    repeat (2) @(negedge clock);
    a_ap_done[3] = 1'b1; a_ap_continue[3] = 1'b0; a_cnt_clr[3] = 1'b1; a_ap_ready[3] = 1'b1;
    @(negedge clock);
    a_ap_done[3] = 1'b0; a_cnt_clr[3] = 1'b0; a_ap_ready[3] = 1'b0;
    a_read(3, 4, 32'd0, "ch3_clr_stall");
    a_read(3, 0, 32'd0, "ch3_clr_start");
    a_read(3, 1, 32'd0, "ch3_clr_ready");
    a_read(3, 2, 32'd0, "ch3_clr_done");
    a_read(3, 3, 32'd0, "ch3_clr_busy");
    a_read(3, 5, 32'd0, "ch3_clr_last");
    a_read(3, 6, 32'd0, "ch3_clr_max");
    a_read(3, 7, 32'd2, "ch3_state_done_wait");
    a_ap_continue[3] = 1'b1;
    @(negedge clock);
    a_read(3, 7, 32'd0, "ch3_state_idle");
    a_read(3, 2, 32'd1, "ch3_done_after_clr");
    a_read(3, 4, 32'd9, "ch3_stall_after_clr");

    // Instance B: counter and latency saturation, out-of-range channel
    b_ap_start[0] = 1'b1; b_ap_done[0] = 1'b1;
    repeat (20) @(negedge clock);
    b_ap_start[0] = 1'b0; b_ap_done[0] = 1'b0;
    b_read(0, 0, 32'd15, "b_ch0_start_sat");
    b_read(0, 2, 32'd15, "b_ch0_done_sat");
    b_read(0, 5, 32'd0,  "b_ch0_last_lat0");
    b_read(0, 7, 32'd0,  "b_ch0_state");
    b_ap_start[1] = 1'b1;
    @(negedge clock);
    b_ap_start[1] = 1'b0;
    repeat (9) @(negedge clock);
    b_ap_done[1] = 1'b1;
    @(negedge clock);
    b_ap_done[1] = 1'b0;
    b_read(1, 5, 32'd7,  "b_ch1_last_lat_sat");
    b_read(1, 6, 32'd7,  "b_ch1_max_lat_sat");
    b_read(1, 3, 32'd10, "b_ch1_busy");
    b_read(1, 0, 32'd1,  "b_ch1_start");
    b_read(3, 0, 32'd0,  "b_oob_start");
    b_read(3, 7, 32'd0,  "b_oob_status");

    // Reset asserted while every channel of A is BUSY
    a_ap_start = '1;
    @(negedge clock);
    a_ap_start = '0;
    repeat (3) @(negedge clock);
    check("pre_rst_all_busy", {24'd0, a_dbg}, 32'h55);
    a_read(3, 4, 32'd9, "ch3_stall_before_rst");
    #2;
    reset = 1'b0;
    #1;
    check("midrst_a_valid", {31'd0, a_rd_valid}, 32'd0);
    check("midrst_a_data", a_rd_data, 32'd0);
    check("midrst_a_state", {24'd0, a_dbg}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      e = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      a_read_all(c, e, $sformatf("post_rst_ch%0d", c));
    end
    a_ap_start[0] = 1'b1;
    @(negedge clock);
    a_ap_start[0] = 1'b0;
    a_read(0, 0, 32'd1, "post_rst_start_cnt");
    a_read(0, 7, 32'd1, "post_rst_state_busy");
    a_ap_done[0] = 1'b1;
    @(negedge clock);
    a_ap_done[0] = 1'b0;

    repeat (3) @(negedge clock);
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
